axis_pipe_frame_bridge: RTL and testbench

//  Parametrised AHIR-pipe <-> 10G MAC AXI-S bridge with per-direction frame FIFOs.
//  TX: AHIR read pipe -> TX FIFO -> MAC s_axis_tx. Store-and-forward, or cut-through.
//  RX: MAC m_axis_rx -> RX FIFO -> AHIR write pipe. Bad and overflowing frames are dropped.

---
 rtl/axis_pipe_frame_bridge.sv | 188 ++++++++++++++++++
 tb/tb_axis_pipe_frame_bridge.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pipe_frame_bridge.sv
// AHIR pipe <-> 10G MAC AXI-Stream bridge with one frame FIFO per direction.
// TX may run store-and-forward or cut-through; RX drops bad or overflowing frames.
//  rx state | meaning
//  RX_IDLE  | between frames, next valid word starts a frame
//  RX_RECV  | mid-frame, words written speculatively past wr_commit
//  RX_DROP  | frame abandoned for lack of space, discard until tlast
module axis_pipe_frame_bridge #(
   parameter int         DATA_WIDTH   = 32,
   parameter int         TX_DEPTH     = 1024,
   parameter int         RX_DEPTH     = 1024,
   parameter bit         TX_STORE_FWD = 1'b1,
   parameter logic [7:0] IFG_DELAY    = 8'd0,
   localparam int        KW           = DATA_WIDTH / 8,
   localparam int        PW           = DATA_WIDTH + KW + 1
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  read_pipe_req,
   input  logic                  read_pipe_ack,
   input  logic [PW-1:0]         read_pipe_data,
   output logic                  pipe_write_req,
   input  logic                  pipe_write_ack,
   output logic [PW-1:0]         pipe_write_data,
   output logic [DATA_WIDTH-1:0] tx_axis_tdata,
   output logic [KW-1:0]         tx_axis_tkeep,
   output logic                  tx_axis_tlast,
   output logic                  tx_axis_tvalid,
   input  logic                  tx_axis_tready,
   output logic                  tx_axis_tuser,
   input  logic [DATA_WIDTH-1:0] rx_axis_tdata,
   input  logic [KW-1:0]         rx_axis_tkeep,
   input  logic                  rx_axis_tlast,
   input  logic                  rx_axis_tvalid,
   input  logic                  rx_axis_tuser,
   output logic [7:0]            tx_ifg_delay,
   output logic [15:0]           rx_drop_count,
   output logic                  rx_overflow
);

   localparam int TAW = $clog2(TX_DEPTH);
   localparam int RAW = $clog2(RX_DEPTH);

   typedef enum logic [1:0] {RX_IDLE, RX_RECV, RX_DROP} rx_state_t;

   // ---------------- TX ----------------
   logic [PW-1:0] tx_mem [TX_DEPTH];
   logic [TAW:0]  tx_wr_q, tx_rd_q;
   logic [TAW+1:0] tx_frames_q;
   logic [PW-1:0] tx_out_q;
   logic          tx_out_vld_q, tx_in_frame_q, run_q;
   logic          tx_full, tx_empty, tx_push, tx_beat, tx_pop, tx_push_last, tx_beat_last;

   assign tx_full  = (tx_wr_q[TAW] != tx_rd_q[TAW]) && (tx_wr_q[TAW-1:0] == tx_rd_q[TAW-1:0]);
   assign tx_empty = (tx_wr_q == tx_rd_q);

   // run_q keeps the pipe request low for the cycle following reset
   assign read_pipe_req  = run_q && !tx_full;
   assign tx_push        = read_pipe_req && read_pipe_ack;
   assign tx_push_last   = tx_push && read_pipe_data[PW-1];
   // tx_full lets a frame larger than the FIFO stream out cut-through
   assign tx_axis_tvalid = tx_out_vld_q &&
                           (tx_in_frame_q || (tx_frames_q != '0) || !TX_STORE_FWD || tx_full);
   assign tx_beat        = tx_axis_tvalid && tx_axis_tready;
   assign tx_beat_last   = tx_beat && tx_out_q[PW-1];
   assign tx_pop         = !tx_empty && (!tx_out_vld_q || tx_beat);

   assign tx_axis_tdata  = tx_out_q[DATA_WIDTH-1:0];
   assign tx_axis_tkeep  = tx_out_q[DATA_WIDTH +: KW];
   assign tx_axis_tlast  = tx_out_q[PW-1];
   assign tx_axis_tuser  = 1'b0;
   assign tx_ifg_delay   = IFG_DELAY;

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr_q[TAW-1:0]] <= read_pipe_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         run_q         <= 1'b0;
         tx_wr_q       <= '0;
         tx_rd_q       <= '0;
         tx_frames_q   <= '0;
         tx_out_q      <= '0;
         tx_out_vld_q  <= 1'b0;
         tx_in_frame_q <= 1'b0;
      end else begin
         run_q <= 1'b1;
         if (tx_push) tx_wr_q <= tx_wr_q + (TAW+1)'(1);
         if (tx_pop) begin
            tx_rd_q      <= tx_rd_q + (TAW+1)'(1);
            tx_out_q     <= tx_mem[tx_rd_q[TAW-1:0]];
            tx_out_vld_q <= 1'b1;
         end else if (tx_beat) begin
            tx_out_vld_q <= 1'b0;
         end
         if (tx_push_last && !tx_beat_last)
            tx_frames_q <= tx_frames_q + (TAW+2)'(1);
         else if (!tx_push_last && tx_beat_last)
            tx_frames_q <= tx_frames_q - (TAW+2)'(1);
         if (tx_beat) tx_in_frame_q <= !tx_out_q[PW-1];
      end
   end

   // ---------------- RX ----------------
   logic [PW-1:0] rx_mem [RX_DEPTH];
   rx_state_t     rx_state_q, rx_state_d;
   logic [RAW:0]  rx_wr_q, rx_wr_d, rx_cm_q, rx_cm_d, rx_rd_q;
   logic [PW-1:0] rx_out_q;
   logic          rx_out_vld_q, rx_full, rx_empty, rx_pop, rx_we, rx_drop, ovf_q, ovf_d;
   logic [15:0]   drop_q;

   assign rx_full  = (rx_wr_q[RAW] != rx_rd_q[RAW]) && (rx_wr_q[RAW-1:0] == rx_rd_q[RAW-1:0]);
   assign rx_empty = (rx_rd_q == rx_cm_q);
   assign rx_pop   = !rx_empty && (!rx_out_vld_q || pipe_write_ack);

   assign pipe_write_req  = rx_out_vld_q;
   assign pipe_write_data = rx_out_q;
   assign rx_drop_count   = drop_q;
   assign rx_overflow     = ovf_q;

   always_comb begin
      rx_state_d = rx_state_q;
      rx_wr_d    = rx_wr_q;
      rx_cm_d    = rx_cm_q;
      rx_we      = 1'b0;
      rx_drop    = 1'b0;
      ovf_d      = 1'b0;
      case (rx_state_q)
         RX_IDLE, RX_RECV: begin
            if (rx_axis_tvalid) begin
               if (rx_full) begin
                  rx_wr_d    = rx_cm_q;
                  rx_drop    = 1'b1;
                  ovf_d      = 1'b1;
                  rx_state_d = rx_axis_tlast ? RX_IDLE : RX_DROP;
               end else begin
                  rx_we      = 1'b1;
                  rx_wr_d    = rx_wr_q + (RAW+1)'(1);
                  rx_state_d = RX_RECV;
                  if (rx_axis_tlast && !rx_axis_tuser) begin
                     rx_cm_d    = rx_wr_q + (RAW+1)'(1);
                     rx_state_d = RX_IDLE;
                  end else if (rx_axis_tlast) begin
                     rx_wr_d    = rx_cm_q;
                     rx_drop    = 1'b1;
                     rx_state_d = RX_IDLE;
                  end
               end
            end
         end
         RX_DROP: begin
            if (rx_axis_tvalid && rx_axis_tlast) rx_state_d = RX_IDLE;
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rx_we) rx_mem[rx_wr_q[RAW-1:0]] <= {rx_axis_tlast, rx_axis_tkeep, rx_axis_tdata};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_state_q   <= RX_IDLE;
         rx_wr_q      <= '0;
         rx_cm_q      <= '0;
         rx_rd_q      <= '0;
         rx_out_q     <= '0;
         rx_out_vld_q <= 1'b0;
         drop_q       <= '0;
         ovf_q        <= 1'b0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_wr_q    <= rx_wr_d;
         rx_cm_q    <= rx_cm_d;
         ovf_q      <= ovf_d;
         if (rx_drop && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
         if (rx_pop) begin
            rx_rd_q      <= rx_rd_q + (RAW+1)'(1);
            rx_out_q     <= rx_mem[rx_rd_q[RAW-1:0]];
            rx_out_vld_q <= 1'b1;
         end else if (pipe_write_ack) begin
            rx_out_vld_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_axis_pipe_frame_bridge.sv
// Bench for axis_pipe_frame_bridge: directed frames plus random traffic against
// an in-order word scoreboard for each direction.
module tb_axis_pipe_frame_bridge;
   localparam int DW  = 32;
   localparam int KW  = 4;
   localparam int PW  = 37;
   localparam int TXD = 16;
   localparam int RXD = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          read_pipe_req, read_pipe_ack;
   logic [PW-1:0] read_pipe_data;
   logic          pipe_write_req, pipe_write_ack;
   logic [PW-1:0] pipe_write_data;
   logic [DW-1:0] tx_axis_tdata, rx_axis_tdata;
   logic [KW-1:0] tx_axis_tkeep, rx_axis_tkeep;
   logic          tx_axis_tlast, tx_axis_tvalid, tx_axis_tready, tx_axis_tuser;
   logic          rx_axis_tlast, rx_axis_tvalid, rx_axis_tuser;
   logic [7:0]    tx_ifg_delay;
   logic [15:0]   rx_drop_count;
   logic          rx_overflow;

   always #5 clk = ~clk;

   axis_pipe_frame_bridge #(
      .DATA_WIDTH(DW), .TX_DEPTH(TXD), .RX_DEPTH(RXD),
      .TX_STORE_FWD(1'b1), .IFG_DELAY(8'd0)
   ) dut (
      .clk(clk), .reset(reset),
      .read_pipe_req(read_pipe_req), .read_pipe_ack(read_pipe_ack), .read_pipe_data(read_pipe_data),
      .pipe_write_req(pipe_write_req), .pipe_write_ack(pipe_write_ack), .pipe_write_data(pipe_write_data),
      .tx_axis_tdata(tx_axis_tdata), .tx_axis_tkeep(tx_axis_tkeep), .tx_axis_tlast(tx_axis_tlast),
      .tx_axis_tvalid(tx_axis_tvalid), .tx_axis_tready(tx_axis_tready), .tx_axis_tuser(tx_axis_tuser),
      .rx_axis_tdata(rx_axis_tdata), .rx_axis_tkeep(rx_axis_tkeep), .rx_axis_tlast(rx_axis_tlast),
      .rx_axis_tvalid(rx_axis_tvalid), .rx_axis_tuser(rx_axis_tuser),
      .tx_ifg_delay(tx_ifg_delay), .rx_drop_count(rx_drop_count), .rx_overflow(rx_overflow)
   );

   int checks = 0;
   int failures = 0;

   // reference model state: word streams in, expected word streams out
   logic [PW-1:0] tx_in_q[$], tx_exp_q[$], rx_exp_q[$];
   logic [PW:0]   rx_in_q[$];
   int            rx_len_q[$];
   int            exp_drops = 0, ovf_seen = 0, lasts_in = 0, lasts_out = 0, rx_pending = 0, rx_cur_len = 0;
   bit            rx_mid = 0, req_low_seen = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic gen_tx_frame(input int len, input logic [KW-1:0] last_keep);
      logic [PW-1:0] w;
      for (int i = 0; i < len; i++) begin
         w = {(i == len - 1), ((i == len - 1) ? last_keep : {KW{1'b1}}), DW'($urandom)};
         tx_in_q.push_back(w);
         tx_exp_q.push_back(w);
      end
   endtask

   task automatic gen_rx_frame(input int len, input bit bad, input bit delivered);
      logic [PW-1:0] w;
      logic          u;
      for (int i = 0; i < len; i++) begin
         w = {(i == len - 1), KW'($urandom), DW'($urandom)};
         u = (i == len - 1) ? bad : 1'($urandom);
         rx_in_q.push_back({u, w});
         if (delivered && !bad) rx_exp_q.push_back(w);
      end
      rx_len_q.push_back(len);
      if (bad) exp_drops++;
   endtask

   task automatic idle_inputs();
      read_pipe_ack  = 1'b0;
      read_pipe_data = '0;
      tx_axis_tready = 1'b0;
      rx_axis_tvalid = 1'b0;
      rx_axis_tdata  = '0;
      rx_axis_tkeep  = '0;
      rx_axis_tlast  = 1'b0;
      rx_axis_tuser  = 1'b0;
      pipe_write_ack = 1'b0;
   endtask

   task automatic clear_model();
      tx_in_q.delete(); tx_exp_q.delete(); rx_exp_q.delete(); rx_in_q.delete(); rx_len_q.delete();
      exp_drops = 0; ovf_seen = 0; lasts_in = 0; lasts_out = 0; rx_pending = 0; rx_mid = 0;
   endtask

   // One iteration per cycle at the falling edge: sample outputs, decide handshakes, drive inputs.
   task automatic run(input int ack_pct, input int rdy_pct, input int wack_pct, input bit gate,
                      input bit sf_chk, input bit contig, input int budget, input bit fixed,
                      input bit inputs_only);
      int            cyc = 0;
      int            last_beat = -10;
      bit            mid_tx = 0, tx_stall = 0, rx_stall = 0, go;
      logic [PW-1:0] tx_held = '0, rx_held = '0, w;
      logic [PW:0]   r;
      forever begin
         @(negedge clk);
         if (rx_overflow) ovf_seen++;
         if (tx_in_q.size() == 0 && rx_in_q.size() == 0 &&
             (inputs_only || (tx_exp_q.size() == 0 && rx_exp_q.size() == 0))) break;
         if (cyc >= budget) break;
         cyc++;
         if (tx_stall) begin
            check("tx_hold_valid", 64'(tx_axis_tvalid), 64'(1));
            check("tx_hold_word", 64'({tx_axis_tlast, tx_axis_tkeep, tx_axis_tdata}), 64'(tx_held));
         end
         if (sf_chk && tx_axis_tvalid) check("tx_store_fwd_gate", 64'(lasts_in > lasts_out), 64'(1));
         tx_axis_tready = (int'($urandom_range(0, 99)) < rdy_pct);
         tx_stall = 1'b0;
         if (tx_axis_tvalid && tx_axis_tready) begin
            check("tx_beat_expected", 64'(tx_exp_q.size() != 0), 64'(1));
            if (tx_exp_q.size() != 0)
               check("tx_beat_word", 64'({tx_axis_tlast, tx_axis_tkeep, tx_axis_tdata}), 64'(tx_exp_q.pop_front()));
            if (contig && mid_tx) check("tx_contiguous", 64'(cyc), 64'(last_beat + 1));
            last_beat = cyc;
            mid_tx = !tx_axis_tlast;
            if (tx_axis_tlast) lasts_out++;
         end else if (tx_axis_tvalid) begin
            tx_stall = 1'b1;
            tx_held  = {tx_axis_tlast, tx_axis_tkeep, tx_axis_tdata};
         end
         if (!read_pipe_req && tx_in_q.size() > 0) req_low_seen = 1'b1;
         read_pipe_ack  = (tx_in_q.size() > 0) && (int'($urandom_range(0, 99)) < ack_pct);
         read_pipe_data = (tx_in_q.size() > 0) ? tx_in_q[0] : '0;
         if (read_pipe_req && read_pipe_ack) begin
            w = tx_in_q.pop_front();
            if (w[PW-1]) lasts_in++;
         end
         rx_axis_tvalid = 1'b0;
         go = (rx_in_q.size() > 0);
         if (go && !rx_mid && gate && (rx_pending + rx_len_q[0] > RXD)) go = 1'b0;
         if (go) begin
            r = rx_in_q.pop_front();
            if (!rx_mid) rx_cur_len = rx_len_q.pop_front();
            {rx_axis_tuser, rx_axis_tlast, rx_axis_tkeep, rx_axis_tdata} = r;
            rx_axis_tvalid = 1'b1;
            rx_mid = !r[PW-1];
            if (r[PW-1] && !r[PW]) rx_pending += rx_cur_len;
         end
         if (rx_stall) begin
            check("rx_hold_req", 64'(pipe_write_req), 64'(1));
            check("rx_hold_word", 64'(pipe_write_data), 64'(rx_held));
         end
         pipe_write_ack = (int'($urandom_range(0, 99)) < wack_pct);
         rx_stall = pipe_write_req && !pipe_write_ack;
         rx_held  = pipe_write_data;
         if (pipe_write_req && pipe_write_ack) begin
            check("rx_word_expected", 64'(rx_exp_q.size() != 0), 64'(1));
            if (rx_exp_q.size() != 0) check("rx_word", 64'(pipe_write_data), 64'(rx_exp_q.pop_front()));
            rx_pending--;
         end
      end
      idle_inputs();
      if (!fixed) begin
         check("left_tx_in", 64'(tx_in_q.size()), 64'(0));
         check("left_rx_in", 64'(rx_in_q.size()), 64'(0));
         if (!inputs_only) begin
            check("left_tx_exp", 64'(tx_exp_q.size()), 64'(0));
            check("left_rx_exp", 64'(rx_exp_q.size()), 64'(0));
         end
      end
   endtask

   task automatic check_quiet(input string tag);
      repeat (4) @(negedge clk);
      check({tag, "_tvalid_idle"}, 64'(tx_axis_tvalid), 64'(0));
      check({tag, "_wreq_idle"}, 64'(pipe_write_req), 64'(0));
      check({tag, "_drop_count"}, 64'(rx_drop_count), 64'(exp_drops));
   endtask

   initial begin
      idle_inputs();
      repeat (3) @(negedge clk);
      check("rst_read_req", 64'(read_pipe_req), 64'(0));
      check("rst_tvalid", 64'(tx_axis_tvalid), 64'(0));
      check("rst_wreq", 64'(pipe_write_req), 64'(0));
      check("rst_drop_count", 64'(rx_drop_count), 64'(0));
      check("rst_overflow", 64'(rx_overflow), 64'(0));
      check("ifg_delay", 64'(tx_ifg_delay), 64'(0));
      check("tx_tuser", 64'(tx_axis_tuser), 64'(0));
      reset = 1'b0;
      @(negedge clk);

      // T1: store-and-forward 3-word frame, partial last keep
      gen_tx_frame(3, 4'b0011);
      run(100, 100, 100, 1'b0, 1'b1, 1'b1, 200, 1'b0, 1'b0);
      check_quiet("t1");

      // T2: 40-word frame through a 16-deep FIFO, tready 50%
      req_low_seen = 1'b0;
      gen_tx_frame(40, KW'($urandom_range(1, 15)));
      run(100, 50, 100, 1'b0, 1'b0, 1'b0, 2000, 1'b0, 1'b0);
      check("t2_req_dropped_when_full", 64'(req_low_seen), 64'(1));
      check_quiet("t2");

      // T3: good, bad, good RX frames
      gen_rx_frame(5, 1'b0, 1'b1);
      gen_rx_frame(4, 1'b1, 1'b1);
      gen_rx_frame(2, 1'b0, 1'b1);
      run(100, 100, 100, 1'b0, 1'b0, 1'b0, 200, 1'b0, 1'b0);
      check_quiet("t3");

      // T4: 20-word frame overflows a stalled 16-deep RX FIFO, then a 3-word frame
      ovf_seen = 0;
      gen_rx_frame(20, 1'b0, 1'b0);
      exp_drops++;
      gen_rx_frame(3, 1'b0, 1'b1);
      run(100, 100, 0, 1'b0, 1'b0, 1'b0, 100, 1'b0, 1'b1);
      run(100, 100, 100, 1'b0, 1'b0, 1'b0, 100, 1'b0, 1'b0);
      check("t4_overflow_pulses", 64'(ovf_seen), 64'(1));
      check_quiet("t4");

      // T5: reset in the middle of frames in both directions
      gen_tx_frame(10, 4'hF);
      gen_rx_frame(10, 1'b0, 1'b1);
      run(100, 50, 50, 1'b0, 1'b1, 1'b0, 5, 1'b1, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      check("t5_read_req", 64'(read_pipe_req), 64'(0));
      check("t5_tvalid", 64'(tx_axis_tvalid), 64'(0));
      check("t5_wreq", 64'(pipe_write_req), 64'(0));
      check("t5_drop_count", 64'(rx_drop_count), 64'(0));
      check("t5_overflow", 64'(rx_overflow), 64'(0));
      @(negedge clk);
      reset = 1'b0;
      clear_model();
      gen_tx_frame(4, 4'h7);
      gen_rx_frame(3, 1'b0, 1'b1);
      run(100, 100, 100, 1'b0, 1'b1, 1'b0, 200, 1'b0, 1'b0);
      check_quiet("t5");

      // T6: 300 random frames each way with random handshakes
      ovf_seen = 0;
      rx_pending = 0;
      for (int f = 0; f < 300; f++) begin
         gen_tx_frame(int'($urandom_range(1, 12)), KW'($urandom_range(1, 15)));
         gen_rx_frame(int'($urandom_range(1, 12)), ($urandom_range(0, 4) == 0), 1'b1);
      end
      run(70, 60, 60, 1'b1, 1'b1, 1'b0, 30000, 1'b0, 1'b0);
      check("t6_no_overflow", 64'(ovf_seen), 64'(0));
      check_quiet("t6");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
